// File: rtl/posit_pkg.sv
// Shared types and constants for the posit decoder: FSM states, special-word patterns, decoded flags.
package posit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EXTRACT,
    DONE
  } state_t;

  // Widest supported word; narrower decoders slice these patterns.
  localparam int POSIT_MAX_N = 64;
  localparam logic [POSIT_MAX_N-1:0] POSIT_ZERO_MAX = '0;
  localparam logic [POSIT_MAX_N-1:0] POSIT_NAR_MAX  = {1'b1, {(POSIT_MAX_N-1){1'b0}}};

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
  } posit_flags_t;

endpackage

// File: rtl/posit_decoder_if.sv
// Handshake and decoded-field bundle between a posit producer/consumer and posit_decoder.
interface posit_decoder_if #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           IN;
  logic                   out_valid;
  logic                   out_ready;
  logic                   LS;
  logic signed [RS:0]     R_O;
  logic [ES-1:0]          E_O;
  logic signed [ES+RS:0]  LE_O;
  logic [N-1:0]           Mant;
  logic                   zero;
  logic                   inf;

  modport master (
    output in_valid, IN, out_ready,
    input  in_ready, out_valid, LS, R_O, E_O, LE_O, Mant, zero, inf
  );

  modport slave (
    input  in_valid, IN, out_ready,
    output in_ready, out_valid, LS, R_O, E_O, LE_O, Mant, zero, inf
  );
endinterface

// File: rtl/regime_lzd.sv
// Leading-run detector: counts how many bits from the MSB down match the MSB.
module regime_lzd #(
  parameter int N  = 32,
  parameter int RS = $clog2(N)
) (
  input  logic [N-2:0]  bits,
  output logic [RS-1:0] run
);
  logic ended;

  always_comb begin
    run   = '0;
    ended = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!ended && (bits[i] == bits[N-2])) begin
        run = run + 1'b1;
      end else begin
        ended = 1'b1;
      end
    end
  end
endmodule

// File: rtl/posit_decoder.sv
// Posit word decoder (sign, regime, exponent, mantissa) behind a valid/ready handshake.
// Build option POSIT_DECODER_FAST_EN swaps the bit-serial regime scan for a one-cycle run detector.
module posit_decoder
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  posit_decoder_if.slave bus
);
  localparam logic [N-1:0]       NAR_WORD  = POSIT_NAR_MAX[POSIT_MAX_N-1 -: N];
  localparam logic [N-1:0]       ZERO_WORD = POSIT_ZERO_MAX[N-1:0];
  localparam logic [RS-1:0]      RUN_MAX   = RS'(N - 1);
  localparam logic signed [RS:0] K_ONE     = 1;

  state_t                 state;
  logic [N-2:0]           work;
  logic [N-2:0]           in_mag;
  logic                   r0;
  logic [RS-1:0]          run;
  posit_flags_t           flags;
  logic                   out_valid_q;
  logic signed [RS:0]     r_q;
  logic [ES-1:0]          e_q;
  logic signed [ES+RS:0]  le_q;
  logic [N-1:0]           mant_q;

  logic [N-3:0]           rest;
  logic [N-3:0]           frac;
  logic [ES-1:0]          e_val;
  logic signed [RS:0]     run_s;
  logic signed [RS:0]     k_val;
  logic                   special;

  // Only the low N-1 bits of the two's complement matter; the sign is kept separately.
  always_comb begin
    in_mag  = bus.IN[N-1] ? (~bus.IN[N-2:0] + 1'b1) : bus.IN[N-2:0];
    special = (bus.IN == ZERO_WORD) || (bus.IN == NAR_WORD);
    rest    = work[N-3:0];
    e_val   = rest[N-3 -: ES];
    frac    = rest << ES;
    run_s   = $signed({1'b0, run});
    k_val   = r0 ? (run_s - K_ONE) : -run_s;
  end

`ifdef POSIT_DECODER_FAST_EN
  logic [RS-1:0] lzd_run;

  regime_lzd #(
    .N  (N),
    .RS (RS)
  ) u_lzd (
    .bits (work),
    .run  (lzd_run)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      flags       <= '0;
      r_q         <= '0;
      e_q         <= '0;
      le_q        <= '0;
      mant_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work       <= in_mag;
            r0         <= in_mag[N-2];
            run        <= '0;
            flags.sign <= bus.IN[N-1];
            flags.zero <= (bus.IN == ZERO_WORD);
            flags.inf  <= (bus.IN == NAR_WORD);
            r_q        <= '0;
            e_q        <= '0;
            le_q       <= '0;
            mant_q     <= '0;
            state      <= special ? DONE : SCAN;
          end
        end
        SCAN: begin
`ifdef POSIT_DECODER_FAST_EN
          run   <= lzd_run;
          work  <= work << lzd_run;
          state <= EXTRACT;
`else
          // Top bit is the next regime candidate; stop on a terminator or a full-width run.
          if ((work[N-2] == r0) && (run != RUN_MAX)) begin
            run  <= run + 1'b1;
            work <= work << 1;
          end else begin
            state <= EXTRACT;
          end
`endif
        end
        EXTRACT: begin
          r_q         <= k_val;
          e_q         <= e_val;
          le_q        <= {k_val, e_val};
          mant_q      <= {1'b1, frac, 1'b0};
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // Zero/NaR arrive here straight from IDLE and raise valid one cycle later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.LS        = flags.sign;
  assign bus.zero      = flags.zero;
  assign bus.inf       = flags.inf;
  assign bus.R_O       = r_q;
  assign bus.E_O       = e_q;
  assign bus.LE_O      = le_q;
  assign bus.Mant      = mant_q;

endmodule

// File: tb/tb_posit_decoder.sv
// Directed bench for posit_decoder at N=8, ES=2: field values, latency, backpressure, reset abort.
module tb_posit_decoder;
  localparam int N  = 8;
  localparam int ES = 2;
  localparam int RS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  posit_decoder_if #(.N(N), .ES(ES), .RS(RS)) bus ();

  posit_decoder #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int m);
`ifdef POSIT_DECODER_FAST_EN
    return 2 + 0 * m;
`else
    return m + 2;
`endif
  endfunction

  task automatic check_fields(input string tag, input logic ls, input int r, input int e,
                              input int le, input int mant, input logic z, input logic nar);
    chk({tag, ".LS"}, bus.LS, ls);
    chk({tag, ".R_O"}, bus.R_O, r);
    chk({tag, ".E_O"}, bus.E_O, e);
    chk({tag, ".LE_O"}, bus.LE_O, le);
    chk({tag, ".Mant"}, bus.Mant, mant);
    chk({tag, ".zero"}, bus.zero, z);
    chk({tag, ".inf"}, bus.inf, nar);
  endtask

  // Returns the number of edges after the accept edge at which out_valid rose.
  task automatic send(input logic [7:0] w, output int lat, output logic rdy_after);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.IN       = w;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.IN       = '0;
    rdy_after    = bus.in_ready;
    lat          = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic rdy;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.IN        = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", bus.out_valid, 0);
    check_fields("rst", 1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 1);

    send(8'h40, lat, rdy);
    chk("x40.lat", lat, exp_lat(1));
    chk("x40.busy", rdy, 0);
    check_fields("x40", 1'b0, 0, 0, 0, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    chk("x40.out_valid_drop", bus.out_valid, 0);
    chk("x40.in_ready_back", bus.in_ready, 1);

    send(8'h00, lat, rdy);
    chk("x00.lat", lat, 1);
    check_fields("x00", 1'b0, 0, 0, 0, 8'h00, 1'b1, 1'b0);

    send(8'h80, lat, rdy);
    chk("x80.lat", lat, 1);
    chk("x80.zero", bus.zero, 0);
    chk("x80.inf", bus.inf, 1);
    chk("x80.R_O", bus.R_O, 0);
    chk("x80.Mant", bus.Mant, 8'h00);

    send(8'h7F, lat, rdy);
    chk("x7F.lat", lat, exp_lat(7));
    check_fields("x7F", 1'b0, 6, 0, 24, 8'h80, 1'b0, 1'b0);

    send(8'h01, lat, rdy);
    chk("x01.lat", lat, exp_lat(6));
    check_fields("x01", 1'b0, -6, 0, -24, 8'h80, 1'b0, 1'b0);

    send(8'h5A, lat, rdy);
    chk("x5A.lat", lat, exp_lat(1));
    check_fields("x5A", 1'b0, 0, 3, 3, 8'hA0, 1'b0, 1'b0);

    send(8'hA6, lat, rdy);
    chk("xA6.lat", lat, exp_lat(1));
    check_fields("xA6", 1'b1, 0, 3, 3, 8'hA0, 1'b0, 1'b0);

    // Hold the result in DONE for five cycles.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'h5A, lat, rdy);
    chk("stall.lat", lat, exp_lat(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.out_valid", bus.out_valid, 1);
      chk("stall.in_ready", bus.in_ready, 0);
      chk("stall.Mant", bus.Mant, 8'hA0);
      chk("stall.E_O", bus.E_O, 3);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release.out_valid", bus.out_valid, 0);
    chk("release.in_ready", bus.in_ready, 1);

    // Abort a word mid-scan with reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.IN       = 8'h7F;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.IN       = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort.no_valid", seen, 0);
    chk("abort.in_ready", bus.in_ready, 1);
    check_fields("abort", 1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b0);

    send(8'h40, lat, rdy);
    chk("post.lat", lat, exp_lat(1));
    check_fields("post", 1'b0, 0, 0, 0, 8'h80, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/posit_decoder.md
POSIT_DECODER -- requirements
Module: posit_decoder

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter ES, default 2, exponent field width.
REQ-003 SHALL have parameter RS, default $clog2(N), regime magnitude width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  IN carries a posit to decode.
REQ-007 in_ready  output  1  decoder accepts IN this cycle.
REQ-008 IN  input  N  posit word.
REQ-009 out_valid  output  1  decoded fields valid.
REQ-010 out_ready  input  1  consumer accepts decoded fields.
REQ-011 LS  output  1  sign bit of IN.
REQ-012 R_O  output  RS+1 (signed)  regime value k.
REQ-013 E_O  output  ES  exponent field.
REQ-014 LE_O  output  ES+RS+1 (signed)  combined scale {k, E_O}.
REQ-015 Mant  output  N  mantissa, hidden 1 at bit N-1, fraction left-aligned, zero-filled.
REQ-016 zero  output  1  IN was all zeros.
REQ-017 inf  output  1  IN was NaR (1 followed by N-1 zeros).

Function
REQ-018 FSM states IDLE, SCAN, EXTRACT, DONE; in_ready SHALL equal (state==IDLE).
REQ-019 Accept on in_valid&in_ready: capture IN; if IN[N-1] set, hold two's-complement of IN as working word, else IN; LS=IN[N-1].
REQ-020 zero/NaR on accept: IDLE->DONE directly, set zero or inf, all other field outputs 0; out_valid 1 cycle after accept.
REQ-021 Otherwise IDLE->SCAN; r0 = working bit N-2; SCAN shifts working word left one bit per cycle, counting run m of bits equal to r0.
REQ-022 SCAN->EXTRACT when next bit differs from r0 or m reaches N-1 (no terminator).
REQ-023 k = r0 ? m-1 : -m; range -(N-1)..N-2 SHALL fit RS+1 signed bits.
REQ-024 EXTRACT: skip terminator (if present); next ES bits -> E_O, bits past word end read as 0; remaining bits -> Mant[N-2:0] left-aligned, Mant[N-1]=1.
REQ-025 Normal-value latency: out_valid SHALL rise exactly m+2 cycles after the accept edge.
REQ-026 DONE: outputs stable while out_valid&~out_ready; on out_valid&out_ready -> IDLE, out_valid low next cycle.
REQ-027 No new input accepted in the handshake cycle; back-to-back throughput >= 1 word per latency+1 cycles.
REQ-028 Outputs SHALL be registered; no combinational path IN -> any output.

Reset
REQ-029 rst SHALL force IDLE; out_valid=0, LS=0, R_O=0, E_O=0, LE_O=0, Mant=0, zero=0, inf=0; in_ready=1 in cycle after rst deasserts.
REQ-030 rst mid-SCAN/EXTRACT/DONE SHALL discard the word in flight; no out_valid produced for it.

Configuration
REQ-031 Macro POSIT_DECODER_FAST_EN: defined -> SCAN replaced by one-cycle leading-run count; normal latency fixed at 2 cycles.
REQ-032 Macro undefined -> serial SCAN per REQ-021..025; decoded values identical in both builds.

Structure
REQ-033 Shared package posit_pkg SHALL hold FSM state enum, NaR/zero pattern constants, decoded-field struct type.
REQ-034 One sub-module regime_lzd (leading-run detector, returns m) SHALL be instantiated only under POSIT_DECODER_FAST_EN.

Verification (N=8, ES=2)
REQ-035 IN=0x40 -> LS=0, R_O=0, E_O=0, LE_O=0, Mant=0x80; serial out_valid 3 cycles after accept.
REQ-036 IN=0x00 -> zero=1; IN=0x80 -> inf=1; both out_valid 1 cycle after accept.
REQ-037 IN=0x7F -> R_O=6, E_O=0, LE_O=24, Mant=0x80; IN=0x01 -> R_O=-6, LE_O=-24, Mant=0x80.
REQ-038 IN=0x5A -> R_O=0, E_O=3, LE_O=3, Mant=0xA0; IN=0xA6 -> same with LS=1.
REQ-039 out_ready low 5 cycles in DONE -> outputs and out_valid stable, in_ready=0; released -> IDLE next cycle.
REQ-040 rst pulsed during SCAN of 0x7F -> no out_valid, all outputs 0, next input 0x40 decodes per REQ-035.
